// File: rtl/spectrum_screen_writer.sv
// spectrum_screen_writer: ZX Spectrum shadow-screen write side (snoop FIFO, border, flash, optional clear)
// Optional feature macro: SCREEN_WRITER_CLEAR_EN adds the buffer clear engine (CLEAR state, busy).
// Ports:
//   i_buf_write_clk, i_rst_n                          clock, synchronous active-low reset
//   i_cpu_addr, i_cpu_data, i_cpu_mem_wr, i_cpu_io_wr CPU bus snoop
//   i_frame_int, i_clear_req                          frame pulse, clear request
//   o_buf_write, o_buf_write_addr, o_buf_we           screen buffer write port
//   o_border, o_flash_clk                             renderer border colour and flash phase
//   o_busy, o_overflow                                clear in progress, sticky dropped-write flag
module spectrum_screen_writer #(
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] CLEAR_ATTR   = 8'h38,
    parameter int         FLASH_FRAMES = 16
) (
    input  logic        i_buf_write_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_data,
    input  logic        i_cpu_mem_wr,
    input  logic        i_cpu_io_wr,
    input  logic        i_frame_int,
    input  logic        i_clear_req,
    output logic [7:0]  o_buf_write,
    output logic [12:0] o_buf_write_addr,
    output logic        o_buf_we,
    output logic [2:0]  o_border,
    output logic        o_flash_clk,
    output logic        o_busy,
    output logic        o_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FLASH_FRAMES + 1);

    logic [20:0]   r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wptr, r_rptr;
    logic [FW-1:0] r_frames;
    logic [7:0]    r_data;
    logic [12:0]   r_addr;
    logic [2:0]    r_border;
    logic          r_we, r_flash, r_ovf;
    logic          w_hit, w_empty, w_full, w_pop, w_push, w_flash_wrap;
    logic [20:0]   w_head;

    assign w_hit        = i_cpu_mem_wr && (i_cpu_addr[15:13] == 3'b010) && (i_cpu_addr[12:0] < 13'h1B00);
    assign w_empty      = r_wptr == r_rptr;
    assign w_full       = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_push       = w_hit && (!w_full || w_pop);
    assign w_head       = r_mem[r_rptr[AW-1:0]];
    assign w_flash_wrap = r_frames == FW'(FLASH_FRAMES - 1);

`ifdef SCREEN_WRITER_CLEAR_EN
    typedef enum logic {S_IDLE, S_CLEAR} state_t;
    state_t      r_state;
    logic [12:0] r_idx;
    logic        r_busy;
    // The queue is frozen while clearing so CPU writes land on top of the cleared screen.
    assign w_pop  = (r_state == S_IDLE) && !w_empty;
    assign o_busy = r_busy;
`else
    logic w_unused;
    assign w_unused = i_clear_req;
    assign w_pop    = !w_empty;
    assign o_busy   = 1'b0;
`endif

    always_ff @(posedge i_buf_write_clk)
        if (w_push) r_mem[r_wptr[AW-1:0]] <= {i_cpu_addr[12:0], i_cpu_data};

    always_ff @(posedge i_buf_write_clk) begin
        if (!i_rst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_we     <= 1'b0;
            r_data   <= '0;
            r_addr   <= '0;
            r_border <= '0;
            r_flash  <= 1'b0;
            r_frames <= '0;
            r_ovf    <= 1'b0;
`ifdef SCREEN_WRITER_CLEAR_EN
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_busy   <= 1'b0;
`endif
        end else begin
            if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop) r_rptr <= r_rptr + (AW+1)'(1);
            if (w_hit && !w_push) r_ovf <= 1'b1;
            if (i_cpu_io_wr && !i_cpu_addr[0]) r_border <= i_cpu_data[2:0];
            if (i_frame_int) begin
                r_frames <= w_flash_wrap ? '0 : r_frames + FW'(1);
                if (w_flash_wrap) r_flash <= !r_flash;
            end
            r_we <= w_pop;
            if (w_pop) {r_addr, r_data} <= w_head;
`ifdef SCREEN_WRITER_CLEAR_EN
            if (r_state == S_IDLE) begin
                if (i_clear_req) begin
                    r_state <= S_CLEAR;
                    r_idx   <= '0;
                    r_busy  <= 1'b1;
                end
            end else begin
                r_we   <= 1'b1;
                r_addr <= r_idx;
                r_data <= (r_idx < 13'h1800) ? 8'h00 : CLEAR_ATTR;
                r_idx  <= r_idx + 13'd1;
                if (r_idx == 13'h1AFF) begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_ovf   <= 1'b0;
                end
            end
`endif
        end
    end

    assign o_buf_we         = r_we;
    assign o_buf_write      = r_data;
    assign o_buf_write_addr = r_addr;
    assign o_border         = r_border;
    assign o_flash_clk      = r_flash;
    assign o_overflow       = r_ovf;
endmodule

// File: tb/tb_spectrum_screen_writer.sv
// tb_spectrum_screen_writer: randomized self-checking bench for spectrum_screen_writer
module tb_spectrum_screen_writer;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_data = '0;
    logic        mem_wr = 1'b0, io_wr = 1'b0, frame_int = 1'b0, clear_req = 1'b0;
    logic [7:0]  o_buf_write;
    logic [12:0] o_buf_write_addr;
    logic        o_buf_we, o_flash_clk, o_busy, o_overflow;
    logic [2:0]  o_border;
    int checks = 0, errors = 0, cyc = 0;
    logic [12:0] got_a[$], exp_a[$];
    logic [7:0]  got_d[$], exp_d[$];
    int          got_c[$], exp_c[$];

    spectrum_screen_writer dut (
        .i_buf_write_clk(clk), .i_rst_n(rst_n), .i_cpu_addr(cpu_addr), .i_cpu_data(cpu_data),
        .i_cpu_mem_wr(mem_wr), .i_cpu_io_wr(io_wr), .i_frame_int(frame_int), .i_clear_req(clear_req),
        .o_buf_write(o_buf_write), .o_buf_write_addr(o_buf_write_addr), .o_buf_we(o_buf_we),
        .o_border(o_border), .o_flash_clk(o_flash_clk), .o_busy(o_busy), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk)
        if (o_buf_we) begin
            got_a.push_back(o_buf_write_addr);
            got_d.push_back(o_buf_write);
            got_c.push_back(cyc);
        end

    task automatic flush;
        got_a.delete(); got_d.delete(); got_c.delete();
        exp_a.delete(); exp_d.delete(); exp_c.delete();
    endtask

    task automatic idle(input int n);
        mem_wr = 0; io_wr = 0; frame_int = 0; clear_req = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_rst;
        idle(0);
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        flush();
    endtask

    task automatic test_reset;
        do_rst();
        checks++;
        if ({o_buf_we, o_buf_write, o_buf_write_addr, o_border, o_flash_clk, o_busy, o_overflow} !== '0) begin
            errors++;
            $display("FAIL reset outputs: we=%0d data=%h addr=%h border=%0d flash=%0d busy=%0d ovf=%0d, expected all 0",
                     o_buf_we, o_buf_write, o_buf_write_addr, o_border, o_flash_clk, o_busy, o_overflow);
        end
    endtask

    task automatic test_single;
        int c;
        c = cyc;
        cpu_addr = 16'h4000; cpu_data = 8'hAA; mem_wr = 1;
        @(negedge clk);
        idle(4);
        checks++;
        if (got_a.size() != 1 || got_a[0] !== 13'h0000 || got_d[0] !== 8'hAA || got_c[0] != c + 2) begin
            errors++;
            $display("FAIL single_write: n=%0d addr=%h data=%h cyc=%0d, expected n=1 addr=0000 data=aa cyc=%0d",
                     got_a.size(), got_a.size() ? got_a[0] : 13'h0, got_d.size() ? got_d[0] : 8'h0,
                     got_c.size() ? got_c[0] : -1, c + 2);
        end
        flush();
    endtask

    task automatic test_filter;
        logic [15:0] addrs[3];
        int c;
        addrs = '{16'h3FFF, 16'h5B00, 16'h5AFF};
        c = cyc;
        for (int i = 0; i < 3; i++) begin
            cpu_addr = addrs[i]; cpu_data = (i == 2) ? 8'h47 : 8'h11; mem_wr = 1;
            @(negedge clk);
        end
        mem_wr = 0; io_wr = 1; cpu_addr = 16'h4001; cpu_data = 8'h99;
        @(negedge clk);
        idle(4);
        checks++;
        if (got_a.size() != 1 || got_a[0] !== 13'h1AFF || got_d[0] !== 8'h47 || got_c[0] != c + 4) begin
            errors++;
            $display("FAIL screen_filter: n=%0d addr=%h data=%h, expected n=1 addr=1aff data=47",
                     got_a.size(), got_a.size() ? got_a[0] : 13'h0, got_d.size() ? got_d[0] : 8'h0);
        end
        flush();
    endtask

    task automatic test_back_to_back;
        logic [12:0] a;
        for (int i = 0; i < 6; i++) begin
            a = 13'($urandom_range(0, 13'h1AFF));
            cpu_addr = 16'h4000 + 16'(a); cpu_data = 8'($urandom); mem_wr = 1;
            exp_a.push_back(a); exp_d.push_back(cpu_data); exp_c.push_back(cyc + 2);
            @(negedge clk);
        end
        idle(5);
        checks++;
        if (got_a.size() != 6) begin
            errors++;
            $display("FAIL back_to_back count: got %0d writes, expected 6", got_a.size());
        end else
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i] || got_c[i] != exp_c[i]) begin
                    errors++;
                    $display("FAIL back_to_back[%0d]: addr=%h data=%h cyc=%0d, expected addr=%h data=%h cyc=%0d",
                             i, got_a[i], got_d[i], got_c[i], exp_a[i], exp_d[i], exp_c[i]);
                end
            end
        checks++;
        if (o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back overflow: got %0d expected 0", o_overflow);
        end
        flush();
    endtask

    task automatic test_random;
        logic [2:0] eb;
        logic ef;
        int frames, kind;
        do_rst();
        eb = 0; ef = 0; frames = 0;
        for (int n = 0; n < 300; n++) begin
            checks++;
            if (o_border !== eb || o_flash_clk !== ef) begin
                errors++;
                $display("FAIL random border/flash @%0d: border=%0d flash=%0d, expected border=%0d flash=%0d",
                         n, o_border, o_flash_clk, eb, ef);
            end
            kind = $urandom_range(0, 3);
            mem_wr = (kind == 1 || kind == 2); io_wr = (kind == 3);
            cpu_addr = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h4000 + 16'($urandom_range(0, 16'h1AFF));
            cpu_data = 8'($urandom);
            frame_int = ($urandom_range(0, 2) == 0);
            if (mem_wr && cpu_addr >= 16'h4000 && cpu_addr < 16'h5B00) begin
                exp_a.push_back(13'(cpu_addr - 16'h4000)); exp_d.push_back(cpu_data); exp_c.push_back(cyc + 2);
            end
            if (io_wr && cpu_addr % 2 == 0) eb = cpu_data % 8;
            if (frame_int) begin
                frames++;
                if (frames == 16) begin frames = 0; ef = !ef; end
            end
            @(negedge clk);
        end
        idle(5);
        checks++;
        if (got_a.size() != exp_a.size()) begin
            errors++;
            $display("FAIL random count: got %0d writes, expected %0d", got_a.size(), exp_a.size());
        end else
            for (int i = 0; i < exp_a.size(); i++) begin
                checks++;
                if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i] || got_c[i] != exp_c[i]) begin
                    errors++;
                    $display("FAIL random write[%0d]: addr=%h data=%h cyc=%0d, expected addr=%h data=%h cyc=%0d",
                             i, got_a[i], got_d[i], got_c[i], exp_a[i], exp_d[i], exp_c[i]);
                end
            end
        checks++;
        if (o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL random overflow: got %0d expected 0", o_overflow);
        end
        flush();
    endtask

    task automatic test_border_flash;
        do_rst();
        io_wr = 1; cpu_addr = 16'h00FE; cpu_data = 8'h05;
        @(negedge clk);
        io_wr = 0;
        checks++;
        if (o_border !== 3'b101) begin
            errors++;
            $display("FAIL border_set: got %b expected 101", o_border);
        end
        io_wr = 1; cpu_addr = 16'h00FF; cpu_data = 8'h02;
        @(negedge clk);
        io_wr = 0;
        checks++;
        if (o_border !== 3'b101) begin
            errors++;
            $display("FAIL border_odd_port: got %b expected 101", o_border);
        end
        for (int p = 1; p <= 32; p++) begin
            frame_int = 1;
            @(negedge clk);
            frame_int = 0;
            checks++;
            if (o_flash_clk !== 1'((p / 16) % 2)) begin
                errors++;
                $display("FAIL flash after pulse %0d: got %0d expected %0d", p, o_flash_clk, (p / 16) % 2);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

`ifdef SCREEN_WRITER_CLEAR_EN
    task automatic test_clear;
        int c;
        do_rst();
        c = cyc;
        clear_req = 1;
        @(negedge clk);
        clear_req = 0;
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_busy_start: got %0d expected 1", o_busy);
        end
        repeat (9) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            cpu_addr = 16'h4000 + 16'($urandom_range(0, 16'h1AFF)); cpu_data = 8'($urandom); mem_wr = 1;
            clear_req = (i == 2);
            if (i < 4) begin exp_a.push_back(13'(cpu_addr - 16'h4000)); exp_d.push_back(cpu_data); end
            @(negedge clk);
        end
        idle(0);
        checks++;
        if (o_overflow !== 1'b1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_overflow: ovf=%0d busy=%0d, expected ovf=1 busy=1", o_overflow, o_busy);
        end
        idle(6930);
        checks++;
        if (got_a.size() != 6916) begin
            errors++;
            $display("FAIL clear count: got %0d writes, expected 6916", got_a.size());
        end else
            for (int i = 0; i < 6916; i++) begin
                checks++;
                if (i < 6912 ? (got_a[i] !== 13'(i) || got_d[i] !== (i < 16'h1800 ? 8'h00 : 8'h38))
                             : (got_a[i] !== exp_a[i - 6912] || got_d[i] !== exp_d[i - 6912])
                    || got_c[i] != c + 2 + i) begin
                    errors++;
                    $display("FAIL clear write[%0d]: addr=%h data=%h cyc=%0d, expected cyc=%0d",
                             i, got_a[i], got_d[i], got_c[i], c + 2 + i);
                end
            end
        checks++;
        if (o_busy !== 1'b0 || o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL clear_end: busy=%0d ovf=%0d, expected 0 0", o_busy, o_overflow);
        end
        flush();
    endtask

    task automatic test_abort;
        int c;
        do_rst();
        io_wr = 1; cpu_addr = 16'h00FE; cpu_data = 8'h07;
        @(negedge clk);
        io_wr = 0;
        c = cyc;
        clear_req = 1;
        @(negedge clk);
        clear_req = 0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            cpu_addr = 16'h4000 + 16'(i); cpu_data = 8'h5A; mem_wr = 1;
            @(negedge clk);
        end
        idle(0);
        while (cyc < c + 100) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_buf_we !== 1'b0 || o_border !== 3'b000 || o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL abort: busy=%0d we=%0d border=%0d ovf=%0d, expected all 0",
                     o_busy, o_buf_we, o_border, o_overflow);
        end
        rst_n = 1;
        flush();
        idle(10);
        checks++;
        if (got_a.size() != 0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_fifo_empty: %0d writes busy=%0d after reset, expected 0 0", got_a.size(), o_busy);
        end
        flush();
    endtask
`else
    task automatic test_clear_ignored;
        int busy_seen;
        do_rst();
        busy_seen = 0;
        clear_req = 1; mem_wr = 1; cpu_addr = 16'h4123; cpu_data = 8'h3C;
        @(negedge clk);
        idle(0);
        for (int i = 0; i < 6; i++) begin
            busy_seen += o_busy;
            @(negedge clk);
        end
        checks++;
        if (busy_seen != 0 || got_a.size() != 1 || got_a[0] !== 13'h0123 || got_d[0] !== 8'h3C) begin
            errors++;
            $display("FAIL clear_ignored: busy_cycles=%0d writes=%0d, expected 0 busy and one write 0123<-3c",
                     busy_seen, got_a.size());
        end
        flush();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_filter();
        test_back_to_back();
        test_random();
        test_border_flash();
`ifdef SCREEN_WRITER_CLEAR_EN
        test_clear();
        test_abort();
`else
        test_clear_ignored();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spectrum_screen_writer.md
# spectrum_screen_writer

Write side of the ZX Spectrum shadow screen buffer. Snoops CPU memory writes to 0x4000–0x5AFF, queues them in a small FIFO and replays them into the dual-port screen buffer's write port. Also holds the border colour from ULA port writes, generates the flash clock from frame interrupts, and optionally clears the buffer on request. Output ports drive the screen renderer's `buf_write*`, `border` and `flash_clk` inputs directly.

## Interface
- `FIFO_DEPTH`, 4: write-queue entries; power of 2, ≥2.
- `CLEAR_ATTR`, 8'h38: attribute byte written by the clear engine (white paper, black ink).
- `FLASH_FRAMES`, 16: `frame_int` pulses per `flash_clk` half-period.

- `buf_write_clk`  in  1  single clock for the whole block (CPU/system clock)
- `rst_n`  in  1  synchronous, active-low reset
- `cpu_addr`  in  16  CPU address, valid with either strobe
- `cpu_data`  in  8  CPU write data, valid with either strobe
- `cpu_mem_wr`  in  1  one-cycle memory-write strobe
- `cpu_io_wr`  in  1  one-cycle I/O-write strobe
- `frame_int`  in  1  one-cycle pulse per video frame
- `clear_req`  in  1  one-cycle clear request
- `buf_write`  out  8  buffer write data
- `buf_write_addr`  out  13  buffer write address
- `buf_we`  out  1  buffer write enable, one cycle per byte
- `border`  out  3  border colour {G,R,B} order as CPU bits [2:0]
- `flash_clk`  out  1  flash phase
- `busy`  out  1  clear in progress
- `overflow`  out  1  sticky: a screen write was dropped

## Operation
- Reset (sync, `rst_n`=0 at an edge): FIFO empty, `buf_we`=0, `buf_write`=0, `buf_write_addr`=0, `border`=0, `flash_clk`=0, frame counter 0, `busy`=0, `overflow`=0, state IDLE.
- Screen hit: `cpu_mem_wr` & `cpu_addr[15:13]`=3'b010 & `cpu_addr[12:0]` < 13'h1B00. Entry = {`cpu_addr[12:0]`, `cpu_data`}. Pixels map to 0x0000–0x17FF, attributes to 0x1800–0x1AFF. Non-hits ignored.
- Push accepted if FIFO not full, or full with a pop in the same cycle. Otherwise entry dropped and `overflow` set. `overflow` clears only on reset or on clear completion.
- Border: `cpu_io_wr` & `cpu_addr[0]`=0 → `border` <= `cpu_data[2:0]`. Other I/O ignored.
- Flash: count `frame_int` pulses. On the FLASH_FRAMES-th pulse, toggle `flash_clk` and zero the counter.
- States:
  - IDLE: if FIFO non-empty, pop one entry per cycle to the output registers with `buf_we`=1; else `buf_we`=0. `clear_req` → CLEAR with index 0, `busy`=1.
  - CLEAR: one write per cycle at address = index. Data 8'h00 for index < 0x1800, CLEAR_ATTR for 0x1800–0x1AFF. At index 0x1AFF: write, then return to IDLE, `busy`=0, `overflow`=0.
- During CLEAR:
  - FIFO is not popped; CPU hits are still queued and drained after CLEAR, so they overwrite cleared bytes.
  - `clear_req` is ignored.
- `clear_req` in the same cycle as a FIFO pop in IDLE: the pop completes, then CLEAR starts next cycle.

## Timing
- Output registers: `buf_we`, `buf_write`, `buf_write_addr`.
- Hit strobe sampled at edge k with FIFO empty and IDLE: entry stored at edge k; outputs load at edge k+1 with `buf_we`=1 for exactly one cycle. Latency is 1 cycle from store to write.
- Back-to-back hits drain one per cycle in arrival order, with no bubbles.
- Clear takes exactly 6912 consecutive `buf_we` cycles. `busy` is high from the edge after `clear_req` through the last clear write.
- `border` updates at the sampling edge + 1. `flash_clk` toggles at the edge after the qualifying `frame_int`.
- Asserting `rst_n`=0 mid-clear aborts it and empties the FIFO at that edge; `buf_we`=0 the following cycle.

## Configuration
- `SCREEN_WRITER_CLEAR_EN` defined: clear engine and the CLEAR state are present as above.
- `SCREEN_WRITER_CLEAR_EN` undefined:
  - `clear_req` ignored; `busy` tied 0; no CLEAR state.
  - `overflow` clears only on reset.

## Test plan
- Reset then single write 0x4000←0xAA → one `buf_we` pulse, addr 0x0000, data 0xAA, 1 cycle after store.
- Writes to 0x3FFF, 0x5B00 and 0x5AFF←0x47 → only one `buf_we`, addr 0x1AFF, data 0x47.
- Six consecutive hits with FIFO_DEPTH=4, each with a simultaneous pop → all six written in order, `overflow`=0. Then 6 hits during CLEAR → 4 queued, `overflow`=1, and the 4 drain after clear.
- `clear_req` (CLEAR_EN) → 6912 writes: addr 0x0000 data 0x00 … addr 0x17FF data 0x00, addr 0x1800–0x1AFF data 0x38. `busy` low after the last write.
- I/O write addr 0x00FE data 0x05 → `border`=3'b101. I/O write addr 0x00FF → unchanged. 32 `frame_int` pulses → `flash_clk` toggles at pulses 16 and 32.
- `rst_n` low at clear index 100 → `busy`=0, `buf_we`=0 next cycle, FIFO empty, `border`=0.
